// File: rtl/sccb_slave_regfile.sv
// SCCB slave fronting a 256x8 register file. SCL/SDA are filtered with 3-4 iCLK of latency; oRD_DATA lags iRD_ADDR by 1 cycle.
// No backpressure: the bus master owns all timing, and oWR_STB is a single-cycle pulse per written register.
module sccb_slave_regfile #(
  parameter logic [6:0]  DEV_ADDR = 7'h21,
  parameter int unsigned PTR_INC  = 1
) (
  input  logic       iCLK,
  input  logic       iRST_N,
  input  logic       iSCL,
  input  logic       iSDA,
  output logic       oSDA_OE,
  output logic       oWR_STB,
  output logic [7:0] oWR_ADDR,
  output logic [7:0] oWR_DATA,
  input  logic [7:0] iRD_ADDR,
  output logic [7:0] oRD_DATA,
  output logic       oBUSY
);

  typedef enum logic [3:0] {
    IDLE, DEV, DEV_ACK, SUB, SUB_ACK, WDAT, WDAT_ACK, RDAT, RDAT_MACK, WAIT_STOP
  } state_t;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  logic       r_scl_s1, r_scl_s2, r_sda_s1, r_sda_s2;
  logic [1:0] r_scl_h, r_sda_h;
  logic       r_scl_f, r_sda_f, r_scl_fd, r_sda_fd;
  logic [2:0] r_arm;

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      r_scl_s1 <= 1'b1;
      r_scl_s2 <= 1'b1;
      r_sda_s1 <= 1'b1;
      r_sda_s2 <= 1'b1;
      r_scl_h  <= 2'b11;
      r_sda_h  <= 2'b11;
      r_scl_f  <= 1'b1;
      r_sda_f  <= 1'b1;
      r_scl_fd <= 1'b1;
      r_sda_fd <= 1'b1;
      r_arm    <= 3'd0;
    end else begin
      r_scl_s1 <= iSCL;
      r_scl_s2 <= r_scl_s1;
      r_sda_s1 <= iSDA;
      r_sda_s2 <= r_sda_s1;
      r_scl_h  <= {r_scl_h[0], r_scl_s2};
      r_sda_h  <= {r_sda_h[0], r_sda_s2};
      r_scl_f  <= maj3(r_scl_s2, r_scl_h[0], r_scl_h[1]);
      r_sda_f  <= maj3(r_sda_s2, r_sda_h[0], r_sda_h[1]);
      r_scl_fd <= r_scl_f;
      r_sda_fd <= r_sda_f;
      if (r_arm != 3'd7) r_arm <= r_arm + 3'd1;
    end
  end

  // START/STOP are masked until the filter pipeline has refilled after reset,
  // so a reset released mid-transfer cannot fabricate a bus condition.
  logic w_armed, w_scl_rise, w_scl_fall, w_start, w_stop;
  assign w_armed    = (r_arm == 3'd7);
  assign w_scl_rise = r_scl_f & ~r_scl_fd;
  assign w_scl_fall = ~r_scl_f & r_scl_fd;
  assign w_start    = w_armed & r_scl_f & r_scl_fd & r_sda_fd & ~r_sda_f;
  assign w_stop     = w_armed & r_scl_f & r_scl_fd & ~r_sda_fd & r_sda_f;

  state_t     r_state, w_state_nxt;
  logic [3:0] r_cnt, w_cnt_nxt;
  logic [7:0] r_sh, w_sh_nxt;
  logic [7:0] r_ptr, w_ptr_nxt;
  logic       r_oe, w_oe_nxt;
  logic       r_rw, w_rw_nxt;
  logic       w_we;
  logic       r_busy, r_wr_stb;
  logic [7:0] r_wr_addr, r_wr_data, r_rd_data;
  logic [7:0] r_mem [256];
  logic [7:0] w_byte, w_rd_byte;

  assign w_byte    = {r_sh[6:0], r_sda_f};
  assign w_rd_byte = r_mem[r_ptr];

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_sh_nxt    = r_sh;
    w_ptr_nxt   = r_ptr;
    w_oe_nxt    = r_oe;
    w_rw_nxt    = r_rw;
    w_we        = 1'b0;
    if (w_stop) begin
      w_state_nxt = IDLE;
      w_oe_nxt    = 1'b0;
    end else if (w_start) begin
      w_state_nxt = DEV;
      w_oe_nxt    = 1'b0;
      w_cnt_nxt   = 4'd0;
    end else begin
      case (r_state)
        DEV: if (w_scl_rise) begin
          w_sh_nxt  = w_byte;
          w_cnt_nxt = r_cnt + 4'd1;
          if (r_cnt == 4'd7) begin
            if (r_sh[6:0] == DEV_ADDR) begin
              w_rw_nxt    = r_sda_f;
              w_state_nxt = DEV_ACK;
            end else begin
              w_state_nxt = WAIT_STOP;
            end
          end
        end
        DEV_ACK: if (w_scl_fall) begin
          // First fall asserts ACK, second fall ends it and, for a read, presents the MSB.
          if (!r_oe) begin
            w_oe_nxt = 1'b1;
          end else begin
            w_oe_nxt  = 1'b0;
            w_cnt_nxt = 4'd0;
            if (r_rw) begin
              w_state_nxt = RDAT;
              w_sh_nxt    = {w_rd_byte[6:0], 1'b0};
              w_oe_nxt    = ~w_rd_byte[7];
            end else begin
              w_state_nxt = SUB;
            end
          end
        end
        SUB: if (w_scl_rise) begin
          w_sh_nxt  = w_byte;
          w_cnt_nxt = r_cnt + 4'd1;
          if (r_cnt == 4'd7) begin
            w_ptr_nxt   = w_byte;
            w_state_nxt = SUB_ACK;
          end
        end
        SUB_ACK: if (w_scl_fall) begin
          if (!r_oe) begin
            w_oe_nxt = 1'b1;
          end else begin
            w_oe_nxt    = 1'b0;
            w_cnt_nxt   = 4'd0;
            w_state_nxt = WDAT;
          end
        end
        WDAT: if (w_scl_rise) begin
          w_sh_nxt  = w_byte;
          w_cnt_nxt = r_cnt + 4'd1;
          if (r_cnt == 4'd7) begin
            w_we        = 1'b1;
            w_state_nxt = WDAT_ACK;
          end
        end
        WDAT_ACK: if (w_scl_fall) begin
          if (!r_oe) begin
            w_oe_nxt = 1'b1;
          end else begin
            w_oe_nxt    = 1'b0;
            w_cnt_nxt   = 4'd0;
            w_ptr_nxt   = r_ptr + 8'(PTR_INC);
            w_state_nxt = WDAT;
          end
        end
        RDAT: begin
          if (w_scl_rise) begin
            w_cnt_nxt = r_cnt + 4'd1;
          end else if (w_scl_fall) begin
            if (r_cnt == 4'd8) begin
              w_oe_nxt    = 1'b0;
              w_state_nxt = RDAT_MACK;
            end else begin
              w_oe_nxt = ~r_sh[7];
              w_sh_nxt = {r_sh[6:0], 1'b0};
            end
          end
        end
        RDAT_MACK: begin
          // r_cnt==9 marks "master ACKed, reload on the next fall".
          if (w_scl_rise) begin
            w_ptr_nxt = r_ptr + 8'(PTR_INC);
            if (r_sda_f) w_state_nxt = WAIT_STOP;
            else         w_cnt_nxt   = 4'd9;
          end else if (w_scl_fall && r_cnt == 4'd9) begin
            w_cnt_nxt   = 4'd0;
            w_sh_nxt    = {w_rd_byte[6:0], 1'b0};
            w_oe_nxt    = ~w_rd_byte[7];
            w_state_nxt = RDAT;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      r_state   <= IDLE;
      r_cnt     <= 4'd0;
      r_sh      <= 8'd0;
      r_ptr     <= 8'd0;
      r_oe      <= 1'b0;
      r_rw      <= 1'b0;
      r_busy    <= 1'b0;
      r_wr_stb  <= 1'b0;
      r_wr_addr <= 8'd0;
      r_wr_data <= 8'd0;
      r_rd_data <= 8'd0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_sh      <= w_sh_nxt;
      r_ptr     <= w_ptr_nxt;
      r_oe      <= w_oe_nxt;
      r_rw      <= w_rw_nxt;
      r_wr_stb  <= w_we;
      r_rd_data <= r_mem[iRD_ADDR];
      if (w_we) begin
        r_wr_addr <= r_ptr;
        r_wr_data <= w_byte;
      end
      if (w_stop)       r_busy <= 1'b0;
      else if (w_start) r_busy <= 1'b1;
    end
  end

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      for (int i = 0; i < 256; i++) r_mem[i] <= 8'd0;
    end else if (w_we) begin
      r_mem[r_ptr] <= w_byte;
    end
  end

  assign oSDA_OE  = r_oe;
  assign oWR_STB  = r_wr_stb;
  assign oWR_ADDR = r_wr_addr;
  assign oWR_DATA = r_wr_data;
  assign oRD_DATA = r_rd_data;
  assign oBUSY    = r_busy;

endmodule

// File: tb/tb_sccb_slave_regfile.sv
// Bench for sccb_slave_regfile: open-drain bus master plus scoreboard queues drained by monitors.
module tb_sccb_slave_regfile;
  localparam int Q = 10;  // SCL quarter period in iCLK cycles

  logic       iCLK = 1'b0;
  logic       iRST_N = 1'b0;
  logic       m_scl = 1'b1;
  logic       m_sda = 1'b1;
  logic       sda_bus;
  logic [7:0] iRD_ADDR = 8'd0;
  logic       oSDA_OE, oWR_STB, oBUSY;
  logic [7:0] oWR_ADDR, oWR_DATA, oRD_DATA;

  assign sda_bus = m_sda & ~oSDA_OE;

  always #20 iCLK = ~iCLK;

  sccb_slave_regfile dut (
    .iCLK(iCLK), .iRST_N(iRST_N), .iSCL(m_scl), .iSDA(sda_bus),
    .oSDA_OE(oSDA_OE), .oWR_STB(oWR_STB), .oWR_ADDR(oWR_ADDR), .oWR_DATA(oWR_DATA),
    .iRD_ADDR(iRD_ADDR), .oRD_DATA(oRD_DATA), .oBUSY(oBUSY)
  );

  typedef struct { string nm; logic [15:0] v; } item_t;
  item_t       exp_bus[$];
  logic [15:0] act_bus[$];
  item_t       exp_wr[$];
  item_t       exp_rd[$];
  int          n_chk = 0;
  int          n_fail = 0;
  logic        rd_req = 1'b0;
  logic        rd_req_d = 1'b0;
  logic        oe_watch = 1'b0;
  int          oe_viol = 0;

  task automatic check(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", nm, act, exp);
    end
  endtask

  always @(posedge iCLK) rd_req_d <= rd_req;

  initial begin : monitor
    item_t       it;
    logic [15:0] a;
    forever begin
      @(negedge iCLK);
      if (oe_watch && oSDA_OE) oe_viol++;
      if (oWR_STB) begin
        if (exp_wr.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_wr_stb: got addr %h data %h, required no strobe", oWR_ADDR, oWR_DATA);
        end else begin
          it = exp_wr.pop_front();
          check(it.nm, {oWR_ADDR, oWR_DATA}, it.v);
        end
      end
      if (rd_req_d) begin
        it = exp_rd.pop_front();
        check(it.nm, 16'(oRD_DATA), it.v);
      end
      while (act_bus.size() > 0) begin
        a  = act_bus.pop_front();
        it = exp_bus.pop_front();
        check(it.nm, a, it.v);
      end
    end
  end

  initial begin
    #(40 * 60000);
    $display("FAIL timeout: simulation exceeded its cycle budget");
    $fatal(1, "timeout");
  end

  task automatic qwait();
    repeat (Q) @(negedge iCLK);
  endtask

  task automatic bus_start();
    m_sda = 1'b1; qwait();
    m_scl = 1'b1; qwait();
    m_sda = 1'b0; qwait();
    m_scl = 1'b0; qwait();
  endtask

  task automatic bus_stop();
    m_sda = 1'b0; qwait();
    m_scl = 1'b1; qwait();
    m_sda = 1'b1; qwait();
    qwait();
  endtask

  task automatic bus_bit(input logic b, output logic s);
    m_sda = b;    qwait();
    m_scl = 1'b1; qwait();
    s = sda_bus;  qwait();
    m_scl = 1'b0; qwait();
  endtask

  task automatic wr_byte(input logic [7:0] b, input logic ack_exp, input string nm);
    item_t it;
    logic  s;
    it.nm = nm;
    it.v  = 16'(ack_exp);
    exp_bus.push_back(it);
    for (int i = 7; i >= 0; i--) bus_bit(b[i], s);
    bus_bit(1'b1, s);
    act_bus.push_back(16'(s));
  endtask

  task automatic rd_byte(input logic [7:0] e, input logic mack, input string nm);
    item_t      it;
    logic [7:0] v;
    logic       s;
    it.nm = nm;
    it.v  = 16'(e);
    exp_bus.push_back(it);
    for (int i = 7; i >= 0; i--) begin
      bus_bit(1'b1, s);
      v[i] = s;
    end
    bus_bit(mack, s);
    act_bus.push_back(16'(v));
  endtask

  task automatic expect_wr(input logic [7:0] addr, input logic [7:0] data, input string nm);
    item_t it;
    it.nm = nm;
    it.v  = {addr, data};
    exp_wr.push_back(it);
  endtask

  task automatic user_rd(input logic [7:0] addr, input logic [7:0] e, input string nm);
    item_t it;
    @(negedge iCLK);
    it.nm = nm;
    it.v  = 16'(e);
    exp_rd.push_back(it);
    iRD_ADDR = addr;
    rd_req   = 1'b1;
    @(negedge iCLK);
    rd_req   = 1'b0;
  endtask

  initial begin
    logic       s;
    logic [7:0] b;
    repeat (3) @(negedge iCLK);
    check("rst_sda_oe",  16'(oSDA_OE),  16'd0);
    check("rst_wr_stb",  16'(oWR_STB),  16'd0);
    check("rst_wr_addr", 16'(oWR_ADDR), 16'd0);
    check("rst_wr_data", 16'(oWR_DATA), 16'd0);
    check("rst_rd_data", 16'(oRD_DATA), 16'd0);
    check("rst_busy",    16'(oBUSY),    16'd0);
    iRST_N = 1'b1;
    repeat (10) @(negedge iCLK);

    // Single register write
    bus_start();
    check("busy_in_frame", 16'(oBUSY), 16'd1);
    wr_byte(8'h42, 1'b0, "w1_dev_ack");
    wr_byte(8'h12, 1'b0, "w1_sub_ack");
    expect_wr(8'h12, 8'h80, "w1_strobe");
    wr_byte(8'h80, 1'b0, "w1_dat_ack");
    bus_stop();
    check("busy_after_stop", 16'(oBUSY), 16'd0);
    user_rd(8'h12, 8'h80, "rd_port_12");

    // Two-byte burst, address-only phase, then reads that rely on the retained pointer
    bus_start();
    wr_byte(8'h42, 1'b0, "w2_dev_ack");
    wr_byte(8'h0A, 1'b0, "w2_sub_ack");
    expect_wr(8'h0A, 8'h76, "w2_strobe_0a");
    wr_byte(8'h76, 1'b0, "w2_dat0_ack");
    expect_wr(8'h0B, 8'h5C, "w2_strobe_0b");
    wr_byte(8'h5C, 1'b0, "w2_dat1_ack");
    bus_stop();
    bus_start();
    wr_byte(8'h42, 1'b0, "ptr_dev_ack");
    wr_byte(8'h0A, 1'b0, "ptr_sub_ack");
    bus_stop();
    bus_start();
    wr_byte(8'h43, 1'b0, "r1_dev_ack");
    rd_byte(8'h76, 1'b1, "r1_byte_0a");
    bus_stop();
    bus_start();
    wr_byte(8'h43, 1'b0, "r2_dev_ack");
    rd_byte(8'h5C, 1'b1, "r2_byte_ptr_0b");
    bus_stop();
    user_rd(8'h0A, 8'h76, "rd_port_0a");

    // Pointer wrap on write and on an ACKed multi-byte read
    bus_start();
    wr_byte(8'h42, 1'b0, "wrap_dev_ack");
    wr_byte(8'hFF, 1'b0, "wrap_sub_ack");
    expect_wr(8'hFF, 8'h11, "wrap_strobe_ff");
    wr_byte(8'h11, 1'b0, "wrap_dat0_ack");
    expect_wr(8'h00, 8'h22, "wrap_strobe_00");
    wr_byte(8'h22, 1'b0, "wrap_dat1_ack");
    bus_stop();
    user_rd(8'hFF, 8'h11, "rd_port_ff");
    user_rd(8'h00, 8'h22, "rd_port_00");
    bus_start();
    wr_byte(8'h42, 1'b0, "wrap_ptr_dev_ack");
    wr_byte(8'hFF, 1'b0, "wrap_ptr_sub_ack");
    bus_stop();
    bus_start();
    wr_byte(8'h43, 1'b0, "rb_dev_ack");
    rd_byte(8'h11, 1'b0, "rb_byte_ff");
    rd_byte(8'h22, 1'b1, "rb_byte_00");
    bus_stop();

    // Foreign device address
    oe_watch = 1'b1;
    bus_start();
    wr_byte(8'h44, 1'b1, "foreign_dev_nack");
    wr_byte(8'h33, 1'b1, "foreign_dat_nack");
    bus_stop();
    oe_watch = 1'b0;
    check("foreign_oe_cycles", 16'(oe_viol), 16'd0);
    check("foreign_busy_after_stop", 16'(oBUSY), 16'd0);

    // Repeated START after the sub-address turns into a read
    bus_start();
    wr_byte(8'h42, 1'b0, "rs_w_dev_ack");
    wr_byte(8'h20, 1'b0, "rs_w_sub_ack");
    expect_wr(8'h20, 8'h9C, "rs_w_strobe");
    wr_byte(8'h9C, 1'b0, "rs_w_dat_ack");
    bus_stop();
    bus_start();
    wr_byte(8'h42, 1'b0, "rs_dev_ack");
    wr_byte(8'h20, 1'b0, "rs_sub_ack");
    bus_start();
    wr_byte(8'h43, 1'b0, "rs_rd_dev_ack");
    rd_byte(8'h9C, 1'b1, "rs_byte_20");
    bus_stop();

    // Partial data byte cut short by STOP
    bus_start();
    wr_byte(8'h42, 1'b0, "part_dev_ack");
    wr_byte(8'h40, 1'b0, "part_sub_ack");
    bus_bit(1'b1, s);
    bus_bit(1'b0, s);
    bus_bit(1'b1, s);
    bus_bit(1'b0, s);
    bus_stop();
    user_rd(8'h40, 8'h00, "rd_port_40_unwritten");

    // Reset while the slave is driving ACK
    b = 8'h42;
    bus_start();
    for (int i = 7; i >= 0; i--) bus_bit(b[i], s);
    m_sda = 1'b1;
    qwait();
    check("oe_before_rst", 16'(oSDA_OE), 16'd1);
    iRST_N = 1'b0;
    #1;
    check("oe_async_rst", 16'(oSDA_OE), 16'd0);
    check("busy_async_rst", 16'(oBUSY), 16'd0);
    repeat (3) @(negedge iCLK);
    iRST_N = 1'b1;
    m_scl = 1'b1; qwait(); qwait();
    m_scl = 1'b0; qwait();
    wr_byte(8'h55, 1'b1, "post_rst_ignored_nack");
    bus_stop();
    check("post_rst_busy", 16'(oBUSY), 16'd0);

    // Fresh transaction after reset, and reset cleared earlier contents
    bus_start();
    wr_byte(8'h42, 1'b0, "fresh_dev_ack");
    wr_byte(8'h30, 1'b0, "fresh_sub_ack");
    expect_wr(8'h30, 8'hA5, "fresh_strobe");
    wr_byte(8'hA5, 1'b0, "fresh_dat_ack");
    bus_stop();
    user_rd(8'h30, 8'hA5, "rd_port_30");
    user_rd(8'h12, 8'h00, "rd_port_12_cleared");

    repeat (20) @(negedge iCLK);
    check("pending_writes", 16'(exp_wr.size()), 16'd0);
    check("pending_bus_items", 16'(exp_bus.size()), 16'd0);
    check("pending_rd_items", 16'(exp_rd.size()), 16'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
